// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the RV32I pc sequencer: hazard/EX inputs, imem handshake,
// trap reporting and the redirect performance counter.
interface pc_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             fetch_ready;
    logic             trap_ack;
    logic [31:0]      pc;
    logic [31:0]      pcplus4;
    logic             fetch_valid;
    logic             trap;
    logic [31:0]      trap_pc;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        input  stall, redirect_valid, redirect_target, fetch_ready, trap_ack,
        output pc, pcplus4, fetch_valid, trap, trap_pc, redirect_cnt
    );

    modport slave (
        output stall, redirect_valid, redirect_target, fetch_ready, trap_ack,
        input  pc, pcplus4, fetch_valid, trap, trap_pc, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// RV32I program counter and next-PC sequencer: pc+4 advance, stalls, EX redirects,
// imem valid/ready handshake and misaligned-target traps.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT, TRAP} state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      trap_pc_q;
    logic [31:0]      pend_target_q;
    logic             pend_q;
    logic             trap_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pcplus4;
    logic [CNT_W-1:0] cnt_d;
    logic             wait_redirect;
    logic [31:0]      wait_target;

    always_comb begin
        pcplus4       = pc_q + 32'd4;
        cnt_d         = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // A redirect arriving together with fetch_ready supersedes the pending one.
        wait_redirect = bus.redirect_valid || pend_q;
        wait_target   = bus.redirect_valid ? bus.redirect_target : pend_target_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            trap_pc_q     <= '0;
            pend_target_q <= '0;
            pend_q        <= 1'b0;
            trap_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (bus.redirect_valid) begin
                        if (bus.redirect_target[1:0] != 2'b00) begin
                            state_q   <= TRAP;
                            trap_q    <= 1'b1;
                            trap_pc_q <= bus.redirect_target;
                        end else begin
                            pc_q  <= bus.redirect_target;
                            cnt_q <= cnt_d;
                        end
                    end else if (!bus.stall) begin
                        if (bus.fetch_ready) pc_q <= pcplus4;
                        else                 state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.fetch_ready) begin
                        pend_q <= 1'b0;
                        if (!wait_redirect) begin
                            pc_q    <= pcplus4;
                            state_q <= RUN;
                        end else if (wait_target[1:0] != 2'b00) begin
                            state_q   <= TRAP;
                            trap_q    <= 1'b1;
                            trap_pc_q <= wait_target;
                        end else begin
                            pc_q    <= wait_target;
                            cnt_q   <= cnt_d;
                            state_q <= RUN;
                        end
                    end else if (bus.redirect_valid) begin
                        pend_q        <= 1'b1;
                        pend_target_q <= bus.redirect_target;
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) begin
                        pc_q    <= TRAP_VECTOR;
                        trap_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pcplus4      = pcplus4;
    assign bus.fetch_valid  = (state_q == RUN && !bus.stall) || state_q == WAIT;
    assign bus.trap         = trap_q;
    assign bus.trap_pc      = trap_pc_q;
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer, with a reference model of the
// fetch sequencing rules; a second instance runs a 2-bit counter for saturation.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst, stall, rv, ready, ack;
    logic [31:0] rt;

    int checks = 0;
    int errors = 0;

    pc_sequencer_if #(.CNT_W(16)) bus16 ();
    pc_sequencer_if #(.CNT_W(2))  bus2 ();

    assign bus16.stall = stall;           assign bus2.stall = stall;
    assign bus16.redirect_valid = rv;     assign bus2.redirect_valid = rv;
    assign bus16.redirect_target = rt;    assign bus2.redirect_target = rt;
    assign bus16.fetch_ready = ready;     assign bus2.fetch_ready = ready;
    assign bus16.trap_ack = ack;          assign bus2.trap_ack = ack;

    pc_sequencer #(.RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus16));
    pc_sequencer #(.RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Reference model: mode 0 boot, 1 running, 2 waiting on imem, 3 trapped.
    int          m_mode;
    bit          m_valid = 0;
    bit          m_pend, m_trap;
    logic [31:0] m_pc, m_trap_pc, m_pend_t;
    int unsigned m_cnt16, m_cnt2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applied_redirect(input logic [31:0] tgt);
        m_pc = tgt;
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
    endtask

    task automatic model_tick();
        logic [31:0] tgt;
        if (rst) begin
            m_valid = 1; m_mode = 0; m_pc = 0; m_trap = 0; m_trap_pc = 0;
            m_pend = 0; m_cnt16 = 0; m_cnt2 = 0;
            return;
        end
        if (!m_valid) return;
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (rv) begin
                    if (rt % 4 != 0) begin m_mode = 3; m_trap = 1; m_trap_pc = rt; end
                    else applied_redirect(rt);
                end else if (!stall) begin
                    if (ready) m_pc = m_pc + 4;
                    else m_mode = 2;
                end
            end
            2: begin
                if (ready) begin
                    if (rv || m_pend) begin
                        tgt = rv ? rt : m_pend_t;
                        if (tgt % 4 != 0) begin m_mode = 3; m_trap = 1; m_trap_pc = tgt; end
                        else begin applied_redirect(tgt); m_mode = 1; end
                    end else begin
                        m_pc = m_pc + 4; m_mode = 1;
                    end
                    m_pend = 0;
                end else if (rv) begin
                    m_pend = 1; m_pend_t = rt;
                end
            end
            default: if (ack) begin m_pc = 32'h100; m_trap = 0; m_mode = 1; end
        endcase
    endtask

    task automatic compare_model();
        if (!m_valid) return;
        chk("pc", bus16.pc, m_pc);
        chk("pcplus4", bus16.pcplus4, m_pc + 32'd4);
        chk("fetch_valid", {31'b0, bus16.fetch_valid},
            {31'b0, (m_mode == 1 && !stall) || m_mode == 2});
        chk("trap", {31'b0, bus16.trap}, {31'b0, m_trap});
        chk("trap_pc", bus16.trap_pc, m_trap_pc);
        chk("cnt16", {16'b0, bus16.redirect_cnt}, m_cnt16);
        chk("cnt2", {30'b0, bus2.redirect_cnt}, m_cnt2);
        chk("pc2", bus2.pc, m_pc);
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        compare_model();
        model_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stall = 0; rv = 0; rt = 0; ready = 0; ack = 0;
        @(negedge clk);
        step(); step();

        // Reset release: one boot cycle, then sequential fetch
        rst = 0; ready = 1;
        #1;
        chk("t1_boot_fv", {31'b0, bus16.fetch_valid}, 32'd0);
        chk("t1_boot_pc", bus16.pc, 32'h0);
        step();
        chk("t1_pc0", bus16.pc, 32'h0);
        step();
        chk("t1_pc4", bus16.pc, 32'h4);
        step();
        chk("t1_pc8", bus16.pc, 32'h8);
        step();
        chk("t1_pcC", bus16.pc, 32'hC);

        // Redirect beats stall
        stall = 1; rv = 1; rt = 32'h40;
        step();
        rv = 0;
        #1;
        chk("t3_pc", bus16.pc, 32'h40);
        chk("t3_cnt", {16'b0, bus16.redirect_cnt}, 32'd1);
        chk("t3_fv", {31'b0, bus16.fetch_valid}, 32'd0);
        step();
        stall = 0;

        // pc+4 wrap at the top of the address space
        rv = 1; rt = 32'hFFFF_FFFC;
        step();
        rv = 0;
        #1;
        chk("t2_pcplus4", bus16.pcplus4, 32'h0);
        step();
        chk("t2_wrap", bus16.pc, 32'h0);

        // Imem back-pressure with a redirect captured mid-wait
        ready = 0;
        step();
        chk("t4_hold_pc", bus16.pc, 32'h0);
        stall = 1; rv = 1; rt = 32'h80;
        step();
        stall = 0; rv = 0;
        #1;
        chk("t4_wait_pc", bus16.pc, 32'h0);
        chk("t4_wait_fv", {31'b0, bus16.fetch_valid}, 32'd1);
        step();
        ready = 1;
        step();
        chk("t4_pc", bus16.pc, 32'h80);
        chk("t4_cnt", {16'b0, bus16.redirect_cnt}, 32'd3);

        // Misaligned target trap and acknowledge
        rv = 1; rt = 32'h42;
        step();
        rv = 0;
        #1;
        chk("t5_trap", {31'b0, bus16.trap}, 32'd1);
        chk("t5_trap_pc", bus16.trap_pc, 32'h42);
        chk("t5_fv", {31'b0, bus16.fetch_valid}, 32'd0);
        chk("t5_pc", bus16.pc, 32'h80);
        rv = 1; rt = 32'h200;
        step();
        rv = 0; ack = 1;
        step();
        ack = 0;
        #1;
        chk("t5_ack_pc", bus16.pc, 32'h100);
        chk("t5_ack_trap", {31'b0, bus16.trap}, 32'd0);
        chk("t5_keep_trap_pc", bus16.trap_pc, 32'h42);

        // Counter saturation, then reset while waiting with a pending redirect
        rst = 1;
        step();
        rst = 0;
        step();
        for (int i = 1; i <= 5; i++) begin
            rv = 1; rt = 32'(i * 16);
            step();
        end
        rv = 0;
        #1;
        chk("t6_cnt2_sat", {30'b0, bus2.redirect_cnt}, 32'd3);
        chk("t6_cnt16", {16'b0, bus16.redirect_cnt}, 32'd5);
        ready = 0;
        step();
        rv = 1; rt = 32'h300;
        step();
        rv = 0; rst = 1;
        step();
        rst = 0;
        #1;
        chk("t6_rst_pc", bus16.pc, 32'h0);
        chk("t6_rst_fv", {31'b0, bus16.fetch_valid}, 32'd0);
        chk("t6_rst_cnt", {16'b0, bus16.redirect_cnt}, 32'd0);
        ready = 1;
        step();
        chk("t6_run_pc", bus16.pc, 32'h0);
        chk("t6_run_fv", {31'b0, bus16.fetch_valid}, 32'd1);
        step();
        chk("t6_no_pending", bus16.pc, 32'h4);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rv    = ($urandom_range(0, 4) == 0);
            rt    = {$urandom_range(0, 32'h0000_FFFF), 2'b00};
            if ($urandom_range(0, 3) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFFC;
            ready = ($urandom_range(0, 1) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
